// File: rtl/bitscan_pkg.sv
// Shared constants and types for the bit-scan custom-instruction controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bitscan_pkg;

    // Accumulator holds 0..32 inclusive.
    localparam int ACC_W = 6;

    // Custom-instruction opcode field n.
    localparam logic [1:0] OP_CLO    = 2'd0;
    localparam logic [1:0] OP_CLZ    = 2'd1;
    localparam logic [1:0] OP_CTZ    = 2'd2;
    localparam logic [1:0] OP_POPCNT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bitscan_step_scan.sv
// Slice evaluator: leading target-bit run, all-target flag, ones count.
// Latency: purely combinational.
// Backpressure: none; the controller decides when a slice is consumed.
//
// Ports: slice (STEP_W bits, MSB examined first), tgt (bit value being
// counted), run_len (leading tgt run), all_tgt (every bit equals tgt),
// ones (population count of slice).
// Build option BITSCAN_POPCOUNT_EN: when undefined, ones is tied to 0 and
// no counter logic is built.
module step_scan
    import bitscan_pkg::*;
#(
    parameter  int STEP_W = 4,
    localparam int CNT_W  = $clog2(STEP_W + 1)
) (
    input  logic [STEP_W-1:0] slice,
    input  logic              tgt,
    output logic [CNT_W-1:0]  run_len,
    output logic              all_tgt,
    output logic [CNT_W-1:0]  ones
);

    logic run_stop;

    // Count matching bits from the MSB until the first mismatch.
    always_comb begin
        run_len  = '0;
        run_stop = 1'b0;
        for (int i = STEP_W - 1; i >= 0; i--) begin
            if (!run_stop && (slice[i] == tgt)) begin
                run_len = run_len + CNT_W'(1);
            end else begin
                run_stop = 1'b1;
            end
        end
    end

    assign all_tgt = (slice == {STEP_W{tgt}});

`ifdef BITSCAN_POPCOUNT_EN
    always_comb begin
        ones = '0;
        for (int i = 0; i < STEP_W; i++) begin
            ones = ones + CNT_W'(slice[i]);
        end
    end
`else
    assign ones = '0;
`endif

endmodule

// File: rtl/bitscan_ci_ctrl.sv
// Nios II multi-cycle custom instruction: CLO / CLZ / CTZ / POPCNT via step scan.
// Latency: s+1 cycles start->done, s = slices scanned (1..DATA_W/STEP_W).
// Backpressure: start ignored outside IDLE; clk_en low freezes all state.
//
// Ports: clk, reset (sync, active high, beats clk_en), clk_en, start,
// n (opcode), dataa (operand), result (count, 0 unless done), done (pulse).
// Build option BITSCAN_POPCOUNT_EN: enables POPCNT; otherwise opcode 3
// scans one slice and returns 0.
module bitscan_ci_ctrl
    import bitscan_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              start,
    input  logic [1:0]        n,
    input  logic [DATA_W-1:0] dataa,
    output logic [DATA_W-1:0] result,
    output logic              done
);

    localparam int NSTEP = DATA_W / STEP_W;
    localparam int CNT_W = $clog2(STEP_W + 1);
    localparam int SW    = $clog2(NSTEP);

    state_t            state;
    logic [DATA_W-1:0] opnd;
    logic [1:0]        op;
    logic              tgt;
    logic [SW-1:0]     step;
    logic [ACC_W-1:0]  acc;

    logic [DATA_W-1:0] opnd_rev;
    logic [CNT_W-1:0]  run_len;
    logic [CNT_W-1:0]  ones;
    logic              all_tgt;
    logic [ACC_W-1:0]  acc_nxt;
    logic              scan_end;
    logic              is_last;

    // CTZ becomes a leading-zero scan of the reversed operand.
    always_comb begin
        opnd_rev = '0;
        for (int i = 0; i < DATA_W; i++) begin
            opnd_rev[i] = dataa[DATA_W-1-i];
        end
    end

    // The operand register is shifted left each step, so the slice under
    // examination is always the top STEP_W bits.
    step_scan #(.STEP_W(STEP_W)) u_step_scan (
        .slice   (opnd[DATA_W-1 -: STEP_W]),
        .tgt     (tgt),
        .run_len (run_len),
        .all_tgt (all_tgt),
        .ones    (ones)
    );

    always_comb begin
        is_last = (step == SW'(NSTEP - 1));
        if (op == OP_POPCNT) begin
            // ones is constant 0 when POPCNT is not built, leaving acc at 0.
            acc_nxt = acc + ACC_W'(ones);
`ifdef BITSCAN_POPCOUNT_EN
            scan_end = is_last;
`else
            scan_end = 1'b1;
`endif
        end else begin
            acc_nxt  = acc + ACC_W'(run_len);
            scan_end = !all_tgt || is_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            opnd   <= '0;
            op     <= OP_CLO;
            tgt    <= 1'b0;
            step   <= '0;
            acc    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    done   <= 1'b0;
                    result <= '0;
                    if (start) begin
                        opnd  <= (n == OP_CTZ) ? opnd_rev : dataa;
                        op    <= n;
                        tgt   <= (n == OP_CLO);
                        step  <= '0;
                        acc   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    opnd <= opnd << STEP_W;
                    step <= step + SW'(1);
                    acc  <= acc_nxt;
                    if (scan_end) begin
                        done   <= 1'b1;
                        result <= DATA_W'(acc_nxt);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done   <= 1'b0;
                    result <= '0;
                    state  <= IDLE;
                end
                default: begin
                    done   <= 1'b0;
                    result <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitscan_ci_ctrl.sv
// Self-checking bench for bitscan_ci_ctrl: directed corner cases plus
// randomized operations compared against a bit-counting reference model.
// Latency and result are both checked for every operation.
module tb_bitscan_ci_ctrl;
    import bitscan_pkg::*;

    localparam int STEP_W = 4;
    localparam int NSTEP  = 32 / STEP_W;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [1:0]  n;
    logic [31:0] dataa;
    logic [31:0] result;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bitscan_ci_ctrl #(.DATA_W(32), .STEP_W(STEP_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .dataa  (dataa),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    // Reference model: count straight from the bit definitions.
    function automatic int ref_count(input logic [1:0] op, input logic [31:0] d);
        int c = 0;
        case (op)
            2'd0: while (c < 32 && d[31-c] == 1'b1) c++;
            2'd1: while (c < 32 && d[31-c] == 1'b0) c++;
            2'd2: while (c < 32 && d[c] == 1'b0) c++;
            default: c = $countones(d);
        endcase
        return c;
    endfunction

    function automatic int ref_result(input logic [1:0] op, input logic [31:0] d);
`ifdef BITSCAN_POPCOUNT_EN
        return ref_count(op, d);
`else
        return (op == 2'd3) ? 0 : ref_count(op, d);
`endif
    endfunction

    // Slices visited: a run of c target bits ends inside slice c/STEP_W.
    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] d);
        int c;
        int s;
        if (op == 2'd3) begin
`ifdef BITSCAN_POPCOUNT_EN
            s = NSTEP;
`else
            s = 1;
`endif
        end else begin
            c = ref_count(op, d);
            s = c / STEP_W + 1;
            if (s > NSTEP) s = NSTEP;
        end
        return s + 1;
    endfunction

    // Issue one operation and wait for done. Called just after a posedge
    // with the DUT in IDLE; returns just after the edge that raised done.
    task automatic run_op(input logic [1:0] op, input logic [31:0] d, input bit hammer,
                          output int res, output int lat);
        bit got = 0;
        bit bad_res = 0;
        n = op;
        dataa = d;
        start = 1'b1;
        lat = 0;
        res = -1;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (hammer) begin
                n = 2'($urandom);
                dataa = $urandom;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                got = 1;
                res = int'(result);
                start = 1'b0;
            end else if (result != 0) begin
                bad_res = 1;
            end
        end
        start = 1'b0;
        if (!got) check("done_timeout", 32'(lat), 32'(0));
        check("result_zero_while_busy", 32'(bad_res), 32'(0));
    endtask

    task automatic op_check(input logic [1:0] op, input logic [31:0] d,
                            input int exp_res, input int exp_lat, input bit hammer);
        int res;
        int lat;
        run_op(op, d, hammer, res, lat);
        check("result", 32'(res), 32'(exp_res));
        check("latency", 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
    endtask

    initial begin
        int res;
        int lat;
        int cnt;
        int t0;
        logic [1:0]  rop;
        logic [31:0] rd;
        int k;

        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        n      = 2'd0;
        dataa  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", 32'(done), 32'(0));
        check("reset_result", result, 32'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Abort a CLO scan at step 3 with reset while clk_en is low.
        cnt = 0;
        n = OP_CLO; dataa = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (done) cnt++; end
        clk_en = 1'b0;
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; if (done) cnt++; end
        reset = 1'b0;
        check("abort_done", 32'(done), 32'(0));
        check("abort_result", result, 32'(0));
        clk_en = 1'b1;
        repeat (12) begin @(posedge clk); #1; if (done) cnt++; end
        check("abort_no_done", 32'(cnt), 32'(0));
        op_check(OP_CLO, 32'hF000_0000, 4, 3, 0);

        // Directed corner cases.
        op_check(OP_CLO, 32'h0FFF_FFFF, 0, 2, 0);
        op_check(OP_CLO, 32'hFFFF_FFFF, 32, 9, 0);
        op_check(OP_CLO, 32'hFFFF_FFF7, 28, 9, 0);
        op_check(OP_CLZ, 32'h0000_0000, 32, 9, 0);
        op_check(OP_CLZ, 32'h0001_0000, 15, 5, 0);
        op_check(OP_CTZ, 32'h0000_0100, 8, 4, 0);
        op_check(OP_CTZ, 32'h8000_0000, 31, 9, 0);
`ifdef BITSCAN_POPCOUNT_EN
        op_check(OP_POPCNT, 32'hA5A5_A5A5, 16, 9, 0);
        op_check(OP_POPCNT, 32'hFFFF_FFFF, 32, 9, 0);
`else
        op_check(OP_POPCNT, 32'hA5A5_A5A5, 0, 2, 0);
        op_check(OP_POPCNT, 32'hFFFF_FFFF, 0, 2, 0);
`endif

        // start held high with changing operands during the scan.
        op_check(OP_CLZ, 32'h0000_0F00, 20, 7, 1);
        cnt = 0;
        repeat (4) begin @(posedge clk); #1; if (done) cnt++; end
        check("hammer_single_done", 32'(cnt), 32'(0));
        op_check(OP_CTZ, 32'h0001_0000, 16, 6, 1);

        // Back-to-back: next start issued in the IDLE cycle after done.
        for (int i = 0; i < 4; i++) begin
            rop = (i % 2 == 0) ? OP_CLO : OP_CLZ;
            rd  = (i % 2 == 0) ? (32'hFFFF_FFFF << (4 * i + 3)) : (32'hFFFF_FFFF >> (5 * i));
            t0 = cyc;
            run_op(rop, rd, 0, res, lat);
            check("b2b_result", 32'(res), 32'(ref_result(rop, rd)));
            @(posedge clk); #1;
            check("b2b_interval", 32'(cyc - t0), 32'(ref_latency(rop, rd) + 1));
        end

        // clk_en low mid-scan and while done is high.
        n = OP_CLO; dataa = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        repeat (2) begin @(posedge clk); #1; lat++; end
        clk_en = 1'b0;
        repeat (3) begin @(posedge clk); #1; lat++; end
        clk_en = 1'b1;
        while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
        check("stall_latency", 32'(lat), 32'(12));
        check("stall_result", result, 32'(32));
        clk_en = 1'b0;
        cnt = 0;
        repeat (3) begin @(posedge clk); #1; if (done && result == 32'd32) cnt++; end
        check("done_held", 32'(cnt), 32'(3));
        clk_en = 1'b1;
        @(posedge clk); #1;
        check("done_release", 32'(done), 32'(0));
        check("result_release", result, 32'(0));

        // Randomized operations with run-shaped operands.
        for (int i = 0; i < 120; i++) begin
            rop = 2'($urandom_range(0, 3));
            rd  = $urandom;
            k   = $urandom_range(0, 32);
            case ($urandom_range(0, 3))
                0: rd = rd >> k;
                1: rd = ~(rd >> k);
                2: rd = rd << k;
                default: ;
            endcase
            op_check(rop, rd, ref_result(rop, rd), ref_latency(rop, rd), i % 7 == 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bitscan_ci_ctrl.md
# bitscan_ci_ctrl

Multi-cycle Nios II custom-instruction controller for a shared bit-scan datapath: count leading ones, count leading zeros, count trailing zeros and population count. It sequences a narrow step-scan engine over the 32-bit operand, one STEP_W-bit slice per cycle. Scanning stops early when the run ends, trading latency for area against a single-cycle 32-bit priority scanner. It sits on the CPU custom-instruction port and follows the multi-cycle start/done handshake.

## Interface
- DATA_W, 32: operand/result width; fixed at 32 for the Nios II port.
- STEP_W, 4: bits scanned per cycle; legal values are 1, 2, 4, 8. NSTEP = DATA_W/STEP_W.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- clk_en  input  1  when low, all state freezes (no transitions, counters and outputs hold).
- start  input  1  single-cycle request; sampled only in IDLE with clk_en high.
- n  input  2  opcode: 0 CLO, 1 CLZ, 2 CTZ, 3 POPCNT.
- dataa  input  32  operand; captured on the accepted start.
- result  output  32  count, zero-extended; valid only while done is high.
- done  output  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE
    - Accepted start captures the operand, opcode and target bit into registers and clears the accumulator.
    - For CTZ the operand is bit-reversed at capture, so every opcode scans MSB-first.
    - Target bit is 1 for CLO and 0 for CLZ/CTZ.
    - Transition: IDLE → SCAN.
  - SCAN
    - Examines slice [DATA_W-1-k·STEP_W -: STEP_W] for step k = 0..NSTEP-1.
    - CLO/CLZ/CTZ: adds the slice's leading target-bit run length to the accumulator. If the slice is not all target bits, or k = NSTEP-1, the next state is DONE.
    - POPCNT: adds the slice's ones count. Never terminates early; exits to DONE after k = NSTEP-1.
  - DONE
    - done = 1 and result = accumulator for exactly one cycle.
    - Transition: DONE → IDLE.
- Arithmetic and boundary values:
  - Accumulator is 6 bits, range 0..32; no overflow is possible.
  - All-target operand yields 32, e.g. CLO of 0xFFFFFFFF = 32 and CLZ of 0 = 32.
- start outside IDLE is ignored; there is no queuing. n and dataa changing after capture have no effect.
- reset at any time forces IDLE, accumulator 0, done 0, result 0, and aborts any scan in progress; the aborted operation never signals done.
- Reset has priority over clk_en: reset acts even with clk_en low.

## Timing
- Reset values: done = 0, result = 0, state = IDLE.
- start accepted at edge 0.
- First SCAN cycle follows edge 0. Each SCAN cycle consumes one slice.
- done is high in the cycle after the last scanned slice.
- Latency start → done: s+1 cycles, where s is the number of slices scanned (1..NSTEP).
  - With STEP_W = 4, CLO/CLZ/CTZ latency is 2..9 cycles; POPCNT is always 9.
- Back-to-back: a new start is accepted the cycle after done (IDLE), giving a minimum issue interval of s+2 cycles.
- clk_en low stretches latency by the number of frozen cycles. If done is high when clk_en drops, done stays high until clk_en returns.
- result is a registered output and is driven 0 whenever done is 0.

## Configuration
- BITSCAN_POPCOUNT_EN defined: opcode 3 performs POPCNT as described, and the slice ones-count logic is instantiated.
- BITSCAN_POPCOUNT_EN not defined: opcode 3 takes the SCAN path for one slice, then DONE, with result = 0 (latency 2). The ones-count logic is not built.

## Structure
- Package bitscan_pkg holds:
  - opcode constants OP_CLO, OP_CLZ, OP_CTZ, OP_POPCNT;
  - the state enum (IDLE, SCAN, DONE);
  - the accumulator width constant ACC_W = 6.
- One sub-module, step_scan:
  - combinational, parameterised by STEP_W;
  - inputs: slice, target bit;
  - outputs: run length, slice-all-target flag, ones count.
- The controller owns the FSM, the operand/step registers and the accumulator.

## Test plan
- Reset held during a CLO scan of 0xFFFFFFFF at step 3 → done never pulses; after release, done = 0 and result = 0. A subsequent CLO of 0xF0000000 → result 4 at latency 3.
- CLO of 0x0FFFFFFF → result 0, latency 2. CLO of 0xFFFFFFFF → result 32, latency 9. CLO of 0xFFFFFFF7 → result 28, latency 9.
- CLZ of 0x00000000 → 32, latency 9. CLZ of 0x00010000 → 15, latency 5. CTZ of 0x00000100 → 8, latency 4. CTZ of 0x80000000 → 31, latency 9.
- POPCNT of 0xA5A5A5A5 → 16 and of 0xFFFFFFFF → 32, both at latency 9. Without BITSCAN_POPCOUNT_EN → 0 at latency 2.
- start re-asserted every cycle during SCAN → exactly one done per accepted start, and the ignored starts leave result unchanged. Back-to-back CLO/CLZ operations → issue interval equals s+2.
- clk_en dropped for 3 cycles mid-scan and again while done is high → latency grows by 3 and done is held high until clk_en returns, then deasserts after one enabled cycle.
